// File: rtl/axis_packet_adapter_if.sv
// Signal bundle for axis_packet_adapter: input/output AXIS streams, source/sink packet
// handshakes and status. "master" is the adapter side, "slave" is its surroundings.
interface axis_packet_adapter_if #(
    parameter int AXIS_IN_WIDTH  = 8,
    parameter int AXIS_OUT_WIDTH = 8,
    parameter int INP_WIDTH      = 16,
    parameter int OUT_WIDTH      = 16
);
    logic [AXIS_IN_WIDTH-1:0]  s_axis_tdata;
    logic                      s_axis_tvalid;
    logic                      s_axis_tready;
    logic                      s_axis_tlast;
    logic [INP_WIDTH-1:0]      src;
    logic                      src_valid;
    logic                      src_ready;
    logic [OUT_WIDTH-1:0]      snk;
    logic                      snk_valid;
    logic                      snk_ready;
    logic [AXIS_OUT_WIDTH-1:0] m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic                      m_axis_tlast;
    logic                      err_frame;
    logic [15:0]               pkt_in_count;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, src_ready, snk, snk_valid, m_axis_tready,
        output s_axis_tready, src, src_valid, snk_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
               err_frame, pkt_in_count
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, src_ready, snk, snk_valid, m_axis_tready,
        input  s_axis_tready, src, src_valid, snk_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
               err_frame, pkt_in_count
    );
endinterface

// File: rtl/axis_packet_adapter.sv
// AXIS framing layer: deserialises input beats into source packets and serialises
// FIFO-buffered sink packets back onto an AXIS bus with tlast on each packet's final beat.
module axis_packet_adapter #(
    parameter int AXIS_IN_WIDTH  = 8,
    parameter int AXIS_OUT_WIDTH = 8,
    parameter int INP_WIDTH      = 16,
    parameter int OUT_WIDTH      = 16,
    parameter int OUT_DEPTH      = 4
) (
    input logic                   clk,
    input logic                   arstn,
    axis_packet_adapter_if.master bus
);
    localparam int IN_BEATS  = (INP_WIDTH + AXIS_IN_WIDTH - 1) / AXIS_IN_WIDTH;
    localparam int OUT_BEATS = (OUT_WIDTH + AXIS_OUT_WIDTH - 1) / AXIS_OUT_WIDTH;
    localparam int IN_ASM_W  = IN_BEATS * AXIS_IN_WIDTH;
    localparam int OUT_PAD_W = OUT_BEATS * AXIS_OUT_WIDTH;
    localparam int IN_CNT_W  = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int OUT_CNT_W = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam int AW        = $clog2(OUT_DEPTH);
    localparam logic [IN_CNT_W-1:0]  IN_LAST  = IN_CNT_W'(IN_BEATS - 1);
    localparam logic [OUT_CNT_W-1:0] OUT_LAST = OUT_CNT_W'(OUT_BEATS - 1);

    logic [IN_CNT_W-1:0]  in_cnt;
    logic [IN_CNT_W-1:0]  in_slot;
    logic [IN_ASM_W-1:0]  asm_q;
    logic [IN_ASM_W-1:0]  asm_next;
    logic [INP_WIDTH-1:0] src_q;
    logic                 src_valid_q;
    logic                 err_q;
    logic [15:0]          pkt_cnt_q;
    logic                 in_last_beat;
    logic                 s_ready;
    logic                 s_fire;

    assign in_last_beat = (in_cnt == IN_LAST);
    // Hold register may drain and refill on the same edge, so src_ready feeds straight through.
    assign s_ready      = !in_last_beat || !src_valid_q || bus.src_ready;
    assign s_fire       = bus.s_axis_tvalid && s_ready;

    always_comb begin
        in_slot  = IN_LAST - in_cnt;
        asm_next = asm_q;
        asm_next[in_slot * AXIS_IN_WIDTH +: AXIS_IN_WIDTH] = bus.s_axis_tdata;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            in_cnt      <= '0;
            asm_q       <= '0;
            src_q       <= '0;
            src_valid_q <= 1'b0;
            err_q       <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            if (src_valid_q && bus.src_ready) begin
                src_valid_q <= 1'b0;
            end
            if (s_fire) begin
                asm_q <= asm_next;
                if (in_last_beat) begin
                    src_q       <= asm_next[IN_ASM_W-1 -: INP_WIDTH];
                    src_valid_q <= 1'b1;
                    in_cnt      <= '0;
                    pkt_cnt_q   <= pkt_cnt_q + 16'd1;
                end else if (bus.s_axis_tlast) begin
                    in_cnt <= '0;
                    err_q  <= 1'b1;
                end else begin
                    in_cnt <= in_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.s_axis_tready = s_ready;
    assign bus.src           = src_q;
    assign bus.src_valid     = src_valid_q;
    assign bus.err_frame     = err_q;
    assign bus.pkt_in_count  = pkt_cnt_q;

    logic [OUT_WIDTH-1:0]      mem [OUT_DEPTH];
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic [OUT_CNT_W-1:0]      out_cnt;
    logic [OUT_CNT_W-1:0]      out_slot;
    logic [OUT_PAD_W-1:0]      head_pad;
    logic [AXIS_OUT_WIDTH-1:0] m_data;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      m_fire;
    logic                      out_last;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign push     = bus.snk_valid && !full;
    assign out_last = (out_cnt == OUT_LAST);
    assign m_fire   = !empty && bus.m_axis_tready;

    // Empty FIFO drives zero data so the bus is clean out of reset and between packets.
    always_comb begin
        out_slot = OUT_LAST - out_cnt;
        head_pad = '0;
        head_pad[OUT_PAD_W-1 -: OUT_WIDTH] = mem[rd_ptr[AW-1:0]];
        m_data = '0;
        if (!empty) begin
            m_data = head_pad[out_slot * AXIS_OUT_WIDTH +: AXIS_OUT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.snk;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            out_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (m_fire) begin
                if (out_last) begin
                    out_cnt <= '0;
                    rd_ptr  <= rd_ptr + 1'b1;
                end else begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.snk_ready     = !full;
    assign bus.m_axis_tvalid = !empty;
    assign bus.m_axis_tdata  = m_data;
    assign bus.m_axis_tlast  = out_last;
endmodule

// File: tb/tb_axis_packet_adapter.sv
// Bench for axis_packet_adapter: directed scenarios plus random traffic, all checked
// against a queue-based packet model sampled on the falling edge.
module tb_axis_packet_adapter;
    localparam int AXIS_IN_WIDTH  = 8;
    localparam int AXIS_OUT_WIDTH = 8;
    localparam int INP_WIDTH      = 12;
    localparam int OUT_WIDTH      = 12;
    localparam int OUT_DEPTH      = 4;
    localparam int IN_BEATS       = (INP_WIDTH + AXIS_IN_WIDTH - 1) / AXIS_IN_WIDTH;
    localparam int OUT_BEATS      = (OUT_WIDTH + AXIS_OUT_WIDTH - 1) / AXIS_OUT_WIDTH;

    logic clk;
    logic arstn;
    int   n_checks = 0;
    int   n_fail   = 0;

    axis_packet_adapter_if #(
        .AXIS_IN_WIDTH(AXIS_IN_WIDTH), .AXIS_OUT_WIDTH(AXIS_OUT_WIDTH),
        .INP_WIDTH(INP_WIDTH), .OUT_WIDTH(OUT_WIDTH)
    ) bus ();

    axis_packet_adapter #(
        .AXIS_IN_WIDTH(AXIS_IN_WIDTH), .AXIS_OUT_WIDTH(AXIS_OUT_WIDTH),
        .INP_WIDTH(INP_WIDTH), .OUT_WIDTH(OUT_WIDTH), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk),
        .arstn(arstn),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: beats of the packet in progress, packets awaiting src, beats awaiting m_axis.
    logic [AXIS_IN_WIDTH-1:0]  in_beats [$];
    logic [INP_WIDTH-1:0]      exp_src  [$];
    logic [AXIS_OUT_WIDTH:0]   exp_out  [$];
    int                        exp_pkts;
    int                        exp_err;
    int                        occ;
    int                        word;
    logic                      exp_tready;

    always @(negedge clk) begin
        if (!arstn) begin
            in_beats.delete();
            exp_src.delete();
            exp_out.delete();
            exp_pkts = 0;
            exp_err  = 0;
        end else begin
            occ = (exp_out.size() + OUT_BEATS - 1) / OUT_BEATS;
            exp_tready = !((in_beats.size() == IN_BEATS - 1) && (exp_src.size() != 0) && !bus.src_ready);
            check_eq("src_valid", 32'(bus.src_valid), 32'(exp_src.size() != 0));
            check_eq("s_tready", 32'(bus.s_axis_tready), 32'(exp_tready));
            check_eq("snk_ready", 32'(bus.snk_ready), 32'(occ < OUT_DEPTH));
            check_eq("m_tvalid", 32'(bus.m_axis_tvalid), 32'(occ != 0));
            check_eq("err_frame", 32'(bus.err_frame), 32'(exp_err));
            check_eq("pkt_in_count", 32'(bus.pkt_in_count), 32'(exp_pkts & 16'hFFFF));
            if (bus.src_valid && exp_src.size() != 0)
                check_eq("src_data", 32'(bus.src), 32'(exp_src[0]));
            if (bus.m_axis_tvalid && exp_out.size() != 0) begin
                check_eq("m_tdata", 32'(bus.m_axis_tdata), 32'(exp_out[0][AXIS_OUT_WIDTH-1:0]));
                check_eq("m_tlast", 32'(bus.m_axis_tlast), 32'(exp_out[0][AXIS_OUT_WIDTH]));
            end

            if (bus.src_valid && bus.src_ready && exp_src.size() != 0)
                void'(exp_src.pop_front());
            if (bus.s_axis_tvalid && bus.s_axis_tready) begin
                in_beats.push_back(bus.s_axis_tdata);
                if (in_beats.size() == IN_BEATS) begin
                    word = 0;
                    foreach (in_beats[i]) word = (word << AXIS_IN_WIDTH) | int'(in_beats[i]);
                    exp_src.push_back(INP_WIDTH'(word >> (IN_BEATS * AXIS_IN_WIDTH - INP_WIDTH)));
                    in_beats.delete();
                    exp_pkts++;
                end else if (bus.s_axis_tlast) begin
                    in_beats.delete();
                    exp_err = 1;
                end
            end
            if (bus.snk_valid && bus.snk_ready) begin
                word = int'(bus.snk) << (OUT_BEATS * AXIS_OUT_WIDTH - OUT_WIDTH);
                for (int i = 0; i < OUT_BEATS; i++)
                    exp_out.push_back({(i == OUT_BEATS - 1),
                                       AXIS_OUT_WIDTH'(word >> (AXIS_OUT_WIDTH * (OUT_BEATS - 1 - i)))});
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready && exp_out.size() != 0)
                void'(exp_out.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [AXIS_IN_WIDTH-1:0] d, input logic l);
        int n;
        n = 0;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = l;
        bus.s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_axis_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("s_tready_wait", 32'(bus.s_axis_tready), 32'd1);
        tick();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic push_snk(input logic [OUT_WIDTH-1:0] d);
        int n;
        n = 0;
        bus.snk       = d;
        bus.snk_valid = 1'b1;
        @(negedge clk);
        while (!bus.snk_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("snk_ready_wait", 32'(bus.snk_ready), 32'd1);
        tick();
        bus.snk_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        check_eq("rst_s_tready", 32'(bus.s_axis_tready), 32'd1);
        check_eq("rst_src_valid", 32'(bus.src_valid), 32'd0);
        check_eq("rst_src", 32'(bus.src), 32'd0);
        check_eq("rst_snk_ready", 32'(bus.snk_ready), 32'd1);
        check_eq("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check_eq("rst_m_tdata", 32'(bus.m_axis_tdata), 32'd0);
        check_eq("rst_m_tlast", 32'(bus.m_axis_tlast), 32'd0);
        check_eq("rst_err_frame", 32'(bus.err_frame), 32'd0);
        check_eq("rst_pkt_in_count", 32'(bus.pkt_in_count), 32'd0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.src_ready     = 1'b1;
        bus.m_axis_tready = 1'b1;
        while ((bus.m_axis_tvalid || bus.src_valid) && n < 100) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(bus.m_axis_tvalid || bus.src_valid), 32'd0);
    endtask

    initial begin
        int n;
        arstn             = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.src_ready     = 1'b0;
        bus.snk           = '0;
        bus.snk_valid     = 1'b0;
        bus.m_axis_tready = 1'b0;
        repeat (3) tick();
        check_reset_values();
        arstn = 1'b1;
        tick();

        // Input packing
        bus.src_ready = 1'b1;
        send_beat(8'hAB, 1'b0);
        send_beat(8'hC0, 1'b1);
        check_eq("pack_valid", 32'(bus.src_valid), 32'd1);
        check_eq("pack_src", 32'(bus.src), 32'h0ABC);
        check_eq("pack_count", 32'(bus.pkt_in_count), 32'd1);
        tick();
        check_eq("pack_valid_drop", 32'(bus.src_valid), 32'd0);

        // Output serialising
        bus.m_axis_tready = 1'b1;
        push_snk(12'h5A3);
        check_eq("ser_b0_valid", 32'(bus.m_axis_tvalid), 32'd1);
        check_eq("ser_b0_data", 32'(bus.m_axis_tdata), 32'h5A);
        check_eq("ser_b0_last", 32'(bus.m_axis_tlast), 32'd0);
        tick();
        check_eq("ser_b1_data", 32'(bus.m_axis_tdata), 32'h30);
        check_eq("ser_b1_last", 32'(bus.m_axis_tlast), 32'd1);
        tick();
        check_eq("ser_done", 32'(bus.m_axis_tvalid), 32'd0);

        // Framing error
        send_beat(8'h11, 1'b1);
        check_eq("frm_no_valid", 32'(bus.src_valid), 32'd0);
        check_eq("frm_err", 32'(bus.err_frame), 32'd1);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        check_eq("frm_src", 32'(bus.src), 32'h223);
        check_eq("frm_err_sticky", 32'(bus.err_frame), 32'd1);
        check_eq("frm_count", 32'(bus.pkt_in_count), 32'd2);
        tick();

        // Output backpressure
        bus.m_axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++) push_snk(OUT_WIDTH'(i));
        check_eq("full_ready", 32'(bus.snk_ready), 32'd0);
        bus.snk       = 12'h005;
        bus.snk_valid = 1'b1;
        repeat (3) begin
            tick();
            check_eq("full_hold", 32'(bus.snk_ready), 32'd0);
        end
        bus.m_axis_tready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.snk_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("full_release_lat", 32'(n), 32'd2);
        tick();
        bus.snk_valid = 1'b0;
        drain("full_drain");
        check_eq("full_model_empty", 32'(exp_out.size()), 32'd0);

        // Input backpressure
        bus.src_ready = 1'b0;
        send_beat(8'h12, 1'b0);
        send_beat(8'h34, 1'b0);
        check_eq("bp_held", 32'(bus.src), 32'h123);
        send_beat(8'h56, 1'b0);
        bus.s_axis_tdata  = 8'h78;
        bus.s_axis_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_stall", 32'(bus.s_axis_tready), 32'd0);
        end
        tick();
        bus.src_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release", 32'(bus.s_axis_tready), 32'd1);
        tick();
        bus.s_axis_tvalid = 1'b0;
        check_eq("bp_second", 32'(bus.src), 32'h567);
        check_eq("bp_second_valid", 32'(bus.src_valid), 32'd1);
        tick();

        // Reset mid-packet
        bus.m_axis_tready = 1'b0;
        push_snk(12'h0AA);
        push_snk(12'h0BB);
        send_beat(8'h77, 1'b0);
        arstn = 1'b0;
        #1;
        check_reset_values();
        tick();
        tick();
        arstn = 1'b1;
        bus.m_axis_tready = 1'b1;
        send_beat(8'hDE, 1'b0);
        send_beat(8'hF0, 1'b0);
        check_eq("rst_fresh_src", 32'(bus.src), 32'hDEF);
        check_eq("rst_fresh_count", 32'(bus.pkt_in_count), 32'd1);
        repeat (4) begin
            tick();
            check_eq("rst_no_stale", 32'(bus.m_axis_tvalid), 32'd0);
        end

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            bus.s_axis_tvalid = 1'($urandom_range(0, 1));
            bus.s_axis_tdata  = 8'($urandom);
            bus.s_axis_tlast  = ($urandom_range(0, 9) == 0);
            bus.src_ready     = ($urandom_range(0, 3) != 0);
            bus.snk_valid     = 1'($urandom_range(0, 1));
            bus.snk           = 12'($urandom);
            bus.m_axis_tready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.snk_valid     = 1'b0;
        tick();
        drain("rand_drain");
        check_eq("rand_out_empty", 32'(exp_out.size()), 32'd0);
        check_eq("rand_src_empty", 32'(exp_src.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
